// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types and constants for the multiply/divide unit
package mips_pkg;

    localparam int MULDIV_ITER = 32;

    typedef enum logic [1:0] {
        MULT  = 2'b00,
        MULTU = 2'b01,
        DIV   = 2'b10,
        DIVU  = 2'b11
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } muldiv_state_t;

    function automatic logic op_is_div(muldiv_op_t op);
        return (op == DIV) || (op == DIVU);
    endfunction

    function automatic logic op_is_signed(muldiv_op_t op);
        return (op == MULT) || (op == DIV);
    endfunction

endpackage

// File: rtl/muldiv_signctl.sv
// rtl/muldiv_signctl.sv - conditional absolute value and conditional 32/64-bit negate
module muldiv_signctl (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        abs_en_i,
    output logic [31:0] a_abs_o,
    output logic [31:0] b_abs_o,
    input  logic [63:0] val_i,
    input  logic        neg64_i,
    input  logic        neg_hi_i,
    input  logic        neg_lo_i,
    output logic [63:0] val_o
);

    // Operand magnitudes for signed ops; unsigned ops pass through untouched
    always_comb begin
        a_abs_o = (abs_en_i && a_i[31]) ? (~a_i + 32'd1) : a_i;
        b_abs_o = (abs_en_i && b_i[31]) ? (~b_i + 32'd1) : b_i;
    end

    // Result sign fixup: full 64-bit negate for products, independent halves for quotient/remainder
    always_comb begin
        val_o = val_i;
        if (neg64_i) begin
            val_o = ~val_i + 64'd1;
        end else begin
            if (neg_hi_i) begin
                val_o[63:32] = ~val_i[63:32] + 32'd1;
            end
            if (neg_lo_i) begin
                val_o[31:0] = ~val_i[31:0] + 32'd1;
            end
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MULT/MULTU/DIV/DIVU unit with HI/LO; optional MULDIV_EARLY_TERM_EN
module muldiv_unit
    import mips_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [1:0]  Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        HiWrite,
    input  logic        LoWrite,
    input  logic [31:0] WData,
    output logic        Busy,
    output logic        Done,
    output logic        DivZero,
    output logic [31:0] Hi,
    output logic [31:0] Lo
);

    muldiv_state_t state_q, state_d;
    muldiv_op_t    op_q, op_d;
    logic          sign_a_q, sign_a_d;
    logic          sign_b_q, sign_b_d;
    logic [4:0]    cnt_q, cnt_d;
    // Multiply: acc = running product, mcand = shifted multiplicand, mplier = remaining multiplier bits.
    // Divide:   acc[32:0] = partial remainder, mcand[31:0] = divisor, mplier = dividend shifting into quotient.
    logic [63:0]   acc_q, acc_d;
    logic [63:0]   mcand_q, mcand_d;
    logic [31:0]   mplier_q, mplier_d;
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;
    logic          div_zero_q, div_zero_d;

    muldiv_op_t    start_op;
    logic          start_div;
    logic          start_signed;
    logic          cur_div;
    logic          cur_signed;
    logic [31:0]   a_abs, b_abs;
    logic [63:0]   fix_val, fix_res;
    logic [63:0]   mul_sum;
    logic [32:0]   div_shift, div_diff;
    logic          div_ge;
    logic          last_iter;
    logic          early_exit;

    assign start_op     = muldiv_op_t'(Op);
    assign start_div    = op_is_div(start_op);
    assign start_signed = op_is_signed(start_op);
    assign cur_div      = op_is_div(op_q);
    assign cur_signed   = op_is_signed(op_q);

    // Divide packs {remainder, quotient} so the same fixup path serves both op classes
    assign fix_val = cur_div ? {acc_q[31:0], mplier_q} : acc_q;

    muldiv_signctl u_signctl (
        .a_i      (A),
        .b_i      (B),
        .abs_en_i (start_signed),
        .a_abs_o  (a_abs),
        .b_abs_o  (b_abs),
        .val_i    (fix_val),
        .neg64_i  (!cur_div && cur_signed && (sign_a_q ^ sign_b_q)),
        .neg_hi_i (cur_div && cur_signed && sign_a_q),
        .neg_lo_i (cur_div && cur_signed && (sign_a_q ^ sign_b_q)),
        .val_o    (fix_res)
    );

    // One iteration step of shift-add multiply and restoring divide
    always_comb begin
        mul_sum   = acc_q + (mplier_q[0] ? mcand_q : 64'd0);
        div_shift = {acc_q[31:0], mplier_q[31]};
        div_diff  = div_shift - {1'b0, mcand_q[31:0]};
        div_ge    = !div_diff[32];
        last_iter = (cnt_q == 5'(MULDIV_ITER - 1));
`ifdef MULDIV_EARLY_TERM_EN
        // Once only bit 0 of the multiplier is left, this step finishes the product
        early_exit = !cur_div && (mplier_q[31:1] == 31'd0);
`else
        early_exit = 1'b0;
`endif
    end

    // Next-state and datapath control
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        sign_a_d   = sign_a_q;
        sign_b_d   = sign_b_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        div_zero_d = div_zero_q;
        case (state_q)
            IDLE: begin
                if (HiWrite) begin
                    hi_d = WData;
                end
                if (LoWrite) begin
                    lo_d = WData;
                end
                if (Start) begin
                    op_d     = start_op;
                    sign_a_d = start_signed && A[31];
                    sign_b_d = start_signed && B[31];
                    cnt_d    = 5'd0;
                    acc_d    = 64'd0;
                    if (start_div && (B == 32'd0)) begin
                        // Result is known immediately; skip straight to the done pulse
                        hi_d       = A;
                        lo_d       = 32'hFFFF_FFFF;
                        div_zero_d = 1'b1;
                        state_d    = DONE;
                    end else begin
                        div_zero_d = 1'b0;
                        state_d    = CALC;
                        if (start_div) begin
                            mcand_d  = {32'd0, b_abs};
                            mplier_d = a_abs;
                        end else begin
                            mcand_d  = {32'd0, a_abs};
                            mplier_d = b_abs;
                        end
                    end
                end
            end
            CALC: begin
                cnt_d = cnt_q + 5'd1;
                if (cur_div) begin
                    acc_d    = {31'd0, (div_ge ? div_diff : div_shift)};
                    mplier_d = {mplier_q[30:0], div_ge};
                end else begin
                    acc_d    = mul_sum;
                    mcand_d  = {mcand_q[62:0], 1'b0};
                    mplier_d = {1'b0, mplier_q[31:1]};
                end
                if (last_iter || early_exit) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                hi_d    = fix_res[63:32];
                lo_d    = fix_res[31:0];
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and architectural registers; reset aborts any operation and clears HI/LO
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q    <= IDLE;
            op_q       <= MULT;
            sign_a_q   <= 1'b0;
            sign_b_q   <= 1'b0;
            cnt_q      <= 5'd0;
            acc_q      <= 64'd0;
            mcand_q    <= 64'd0;
            mplier_q   <= 32'd0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            sign_a_q   <= sign_a_d;
            sign_b_q   <= sign_b_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign Busy    = (state_q != IDLE);
    assign Done    = (state_q == DONE);
    assign DivZero = div_zero_q;
    assign Hi      = hi_q;
    assign Lo      = lo_q;

endmodule
